layer_sequencer: RTL and testbench

//  Sequences a chain of dense layers through one inference at a time.
//  - Accepts a start request and pulses each layer's inputs_ready in turn.
//  - Waits for that layer's outputs_ready before starting the next layer.
//  - Presents result_valid/result_ready to the host once the last layer is done.
//  - A watchdog flags any layer that never completes. Sits between the host

---
 rtl/layer_sequencer_pkg.sv | 14 +
 rtl/layer_sequencer_seq_watchdog.sv | 40 ++++
 rtl/layer_sequencer.sv | 134 +++++++++++++
 tb/tb_layer_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared state encoding and widths for the layer sequencer
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_WAIT,
        SEQ_DONE,
        SEQ_ERROR
    } seq_state_t;

    localparam int PERF_WIDTH = 32;

endpackage

// File: rtl/layer_sequencer_seq_watchdog.sv
// rtl/layer_sequencer_seq_watchdog.sv - per-layer wait timer that flags a layer which never completes
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            // Watchdog disabled: nothing ever expires.
            logic wd_unused;
            assign wd_unused = clock ^ reset ^ clear ^ enable;
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

            logic [TW-1:0] timer;

            // Count waiting cycles; parks on the last value so it never wraps.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    timer <= '0;
                end else if (clear) begin
                    timer <= '0;
                end else if (enable && (timer != LAST)) begin
                    timer <= timer + 1'b1;
                end
            end

            // Expiry is only meaningful while the sequencer is waiting.
            assign expired = enable && (timer == LAST);
        end
    endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - steps one inference through a chain of dense layers; optional LAYER_SEQUENCER_PERF_EN latency counter
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int LAYER_IDX_W    = $clog2(NUM_LAYERS > 1 ? NUM_LAYERS : 2)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   start_ready,
    output logic [NUM_LAYERS-1:0]  layer_start,
    input  logic [NUM_LAYERS-1:0]  layer_done,
    output logic [LAYER_IDX_W-1:0] layer_index,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   error,
    input  logic                   clear_error,
    output logic [PERF_WIDTH-1:0]  perf_cycles
);

    localparam logic [LAYER_IDX_W-1:0] LAST_IDX = LAYER_IDX_W'(NUM_LAYERS - 1);

    seq_state_t             state;
    logic [LAYER_IDX_W-1:0] idx;
    logic [NUM_LAYERS-1:0]  done_q;
    logic [NUM_LAYERS-1:0]  done_rise;
    logic                   completion;
    logic                   wd_expired;

    // Layers drop outputs_ready when restarted, so only a fresh rising edge counts.
    assign done_rise   = layer_done & ~done_q;
    assign completion  = done_rise[idx];
    assign layer_index = idx;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == SEQ_START),
        .enable (state == SEQ_WAIT),
        .expired(wd_expired)
    );

    // Sequencer FSM with registered host/layer outputs and done-level history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= SEQ_IDLE;
            idx          <= '0;
            done_q       <= '1;
            layer_start  <= '0;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            done_q      <= layer_done;
            layer_start <= '0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        state       <= SEQ_START;
                        idx         <= '0;
                        layer_start <= NUM_LAYERS'(1);
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SEQ_START: begin
                    state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (completion) begin
                        if (idx == LAST_IDX) begin
                            state        <= SEQ_DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            state       <= SEQ_START;
                            idx         <= idx + 1'b1;
                            layer_start <= NUM_LAYERS'(1) << (idx + 1'b1);
                        end
                    end else if (wd_expired) begin
                        state <= SEQ_ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    if (result_ready) begin
                        state        <= SEQ_IDLE;
                        idx          <= '0;
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                    end
                end
                SEQ_ERROR: begin
                    if (clear_error) begin
                        state       <= SEQ_IDLE;
                        idx         <= '0;
                        error       <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

`ifdef LAYER_SEQUENCER_PERF_EN
    logic [PERF_WIDTH-1:0] perf_q;

    // Inference latency: restarts on accept, counts while busy, saturates, holds otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if ((state == SEQ_IDLE) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized self-checking bench for layer_sequencer
module tb_layer_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  layer_done = 3'b000;
    logic        result_ready = 1'b0;
    logic        clear_error = 1'b0;

    logic        a_start_ready, a_busy, a_result_valid, a_error;
    logic [2:0]  a_layer_start;
    logic [1:0]  a_layer_index;
    logic [31:0] a_perf;
    logic        b_start_ready, b_busy, b_result_valid, b_error;
    logic [2:0]  b_layer_start;
    logic [1:0]  b_layer_index;
    logic [31:0] b_perf;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(16)) dut_a (
        .clock(clock), .reset(reset), .start(start), .start_ready(a_start_ready),
        .layer_start(a_layer_start), .layer_done(layer_done), .layer_index(a_layer_index),
        .busy(a_busy), .result_valid(a_result_valid), .result_ready(result_ready),
        .error(a_error), .clear_error(clear_error), .perf_cycles(a_perf)
    );

    layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .start(start), .start_ready(b_start_ready),
        .layer_start(b_layer_start), .layer_done(layer_done), .layer_index(b_layer_index),
        .busy(b_busy), .result_valid(b_result_valid), .result_ready(result_ready),
        .error(b_error), .clear_error(clear_error), .perf_cycles(b_perf)
    );

    task automatic do_reset(input logic [2:0] levels);
        @(posedge clock); #1;
        layer_done = levels; start = 0; result_ready = 0; clear_error = 0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    // One inference: layer i raises done d[i] cycles after its pulse; host waits rd cycles in DONE.
    // Cycle k=0 is the start-accept cycle.
    task automatic run_inf(input int d0, input int d1, input int d2, input int rd);
        int d[3];
        int p[3];
        int e, rv_start, rv_end;
        logic [2:0]  exp_ls;
        logic [1:0]  exp_idx;
        logic        exp_busy, exp_rv, exp_sr;
        logic [31:0] exp_perf;
        d = '{d0, d1, d2};
        p[0] = 1;
        p[1] = p[0] + d[0] + 1;
        p[2] = p[1] + d[1] + 1;
        e = p[2] + d[2];
        rv_start = e + 1;
        rv_end = e + 1 + rd;
`ifdef LAYER_SEQUENCER_PERF_EN
        exp_perf = 32'(e);
`else
        exp_perf = 32'd0;
`endif
        for (int k = 0; k <= rv_end + 1; k++) begin
            @(posedge clock); #1;
            start = (k == 0) || (k >= rv_start && k < rv_end);
            result_ready = (k >= rv_end);
            for (int i = 0; i < 3; i++)
                if (k >= p[i]) layer_done[i] = (k >= p[i] + d[i]);
            @(negedge clock);
            exp_ls = 3'b000;
            exp_idx = 2'd0;
            for (int i = 0; i < 3; i++) begin
                if (p[i] == k) exp_ls[i] = 1'b1;
                if (k >= 1 && k <= rv_end && p[i] <= k) exp_idx = 2'(i);
            end
            exp_busy = (k >= 1 && k <= e);
            exp_rv = (k >= rv_start && k <= rv_end);
            exp_sr = (k == 0) || (k == rv_end + 1);
            checks++; if (a_layer_start !== exp_ls) begin errors++; $display("FAIL layer_start k=%0d got %b exp %b", k, a_layer_start, exp_ls); end
            checks++; if (a_layer_index !== exp_idx) begin errors++; $display("FAIL layer_index k=%0d got %0d exp %0d", k, a_layer_index, exp_idx); end
            checks++; if (a_busy !== exp_busy) begin errors++; $display("FAIL busy k=%0d got %b exp %b", k, a_busy, exp_busy); end
            checks++; if (a_result_valid !== exp_rv) begin errors++; $display("FAIL result_valid k=%0d got %b exp %b", k, a_result_valid, exp_rv); end
            checks++; if (a_start_ready !== exp_sr) begin errors++; $display("FAIL start_ready k=%0d got %b exp %b", k, a_start_ready, exp_sr); end
            checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL error k=%0d got %b exp 0", k, a_error); end
            checks++; if (b_layer_start !== exp_ls) begin errors++; $display("FAIL b_layer_start k=%0d got %b exp %b", k, b_layer_start, exp_ls); end
            checks++; if (b_result_valid !== exp_rv) begin errors++; $display("FAIL b_result_valid k=%0d got %b exp %b", k, b_result_valid, exp_rv); end
            if (exp_rv) begin
                checks++; if (a_perf !== exp_perf) begin errors++; $display("FAIL perf_cycles k=%0d got %0d exp %0d", k, a_perf, exp_perf); end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(3'b000);
        @(negedge clock);
        checks++; if ({a_start_ready, a_busy, a_result_valid, a_error, a_layer_start, a_layer_index} !== 9'b1_0_0_0_000_00) begin
            errors++; $display("FAIL reset_outputs got %b%b%b%b %b %b exp 1000 000 00", a_start_ready, a_busy, a_result_valid, a_error, a_layer_start, a_layer_index);
        end
        checks++; if (a_perf !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d exp 0", a_perf); end
    endtask

    task automatic test_basic();
        run_inf(2, 2, 2, 0);
        run_inf(1, 1, 1, 0);
    endtask

    task automatic test_backpressure();
        run_inf(1, 3, 2, 5);
    endtask

    task automatic test_expire_boundary();
        run_inf(2, 16, 1, 0);
        run_inf(16, 1, 16, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 15; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clock); #1; start = 0;
                @(negedge clock);
                checks++; if (a_start_ready !== 1'b1) begin errors++; $display("FAIL idle_start_ready got %b exp 1", a_start_ready); end
            end
            run_inf($urandom_range(1, 16), $urandom_range(1, 16), $urandom_range(1, 16), $urandom_range(0, 4));
        end
    endtask

    // Layer 1 never completes: 16 WAIT cycles (k=5..20), error visible from k=21.
    task automatic test_timeout();
        logic [2:0] exp_ls;
        for (int k = 0; k <= 24; k++) begin
            @(posedge clock); #1;
            start = (k == 0) || (k >= 22);
            result_ready = 0;
            if (k >= 1) layer_done[0] = (k >= 3);
            if (k >= 4) layer_done[1] = 1'b0;
            @(negedge clock);
            exp_ls = (k == 1) ? 3'b001 : (k == 4) ? 3'b010 : 3'b000;
            checks++; if (a_layer_start !== exp_ls) begin errors++; $display("FAIL to_layer_start k=%0d got %b exp %b", k, a_layer_start, exp_ls); end
            checks++; if (a_error !== (k >= 21)) begin errors++; $display("FAIL to_error k=%0d got %b exp %b", k, a_error, (k >= 21)); end
            checks++; if (a_busy !== (k >= 1 && k <= 20)) begin errors++; $display("FAIL to_busy k=%0d got %b", k, a_busy); end
            checks++; if (a_start_ready !== (k == 0)) begin errors++; $display("FAIL to_start_ready k=%0d got %b", k, a_start_ready); end
        end
        @(posedge clock); #1; start = 0; clear_error = 1;
        @(posedge clock); #1; clear_error = 0;
        @(negedge clock);
        checks++; if (a_start_ready !== 1'b1) begin errors++; $display("FAIL clear_start_ready got %b exp 1", a_start_ready); end
        checks++; if (a_layer_index !== 2'd0) begin errors++; $display("FAIL clear_layer_index got %0d exp 0", a_layer_index); end
        checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL clear_error got %b exp 0", a_error); end
    endtask

    // done[0] high through reset must not count; fall at k=7, rise at k=8 advances.
    task automatic test_held_done();
        logic [2:0] exp_ls;
        logic [1:0] exp_idx;
        do_reset(3'b001);
        for (int k = 0; k <= 14; k++) begin
            @(posedge clock); #1;
            start = (k == 0);
            result_ready = 1;
            layer_done[0] = (k < 7) || (k >= 8);
            layer_done[1] = (k >= 10);
            layer_done[2] = (k >= 12);
            @(negedge clock);
            exp_ls = (k == 1) ? 3'b001 : (k == 9) ? 3'b010 : (k == 11) ? 3'b100 : 3'b000;
            exp_idx = (k >= 11 && k <= 13) ? 2'd2 : (k >= 9 && k <= 10) ? 2'd1 : 2'd0;
            checks++; if (a_layer_start !== exp_ls) begin errors++; $display("FAIL held_layer_start k=%0d got %b exp %b", k, a_layer_start, exp_ls); end
            checks++; if (a_layer_index !== exp_idx) begin errors++; $display("FAIL held_layer_index k=%0d got %0d exp %0d", k, a_layer_index, exp_idx); end
            checks++; if (a_result_valid !== (k == 13)) begin errors++; $display("FAIL held_result_valid k=%0d got %b", k, a_result_valid); end
        end
    endtask

    // Reset while waiting on layer 2, then a full inference must restart at layer 0.
    task automatic test_reset_mid();
        for (int k = 0; k <= 7; k++) begin
            @(posedge clock); #1;
            start = (k == 0);
            result_ready = 0;
            if (k >= 1) layer_done[0] = (k >= 2);
            if (k >= 3) layer_done[1] = (k >= 4);
            if (k >= 5) layer_done[2] = 1'b0;
        end
        @(negedge clock);
        checks++; if (a_busy !== 1'b1 || a_layer_index !== 2'd2) begin errors++; $display("FAIL mid_wait busy %b idx %0d exp 1 2", a_busy, a_layer_index); end
        #2 reset = 1;
        #1;
        checks++; if ({a_busy, a_result_valid, a_error, a_layer_start, a_layer_index} !== 8'b0) begin
            errors++; $display("FAIL mid_reset_outputs got %b%b%b %b %b exp all 0", a_busy, a_result_valid, a_error, a_layer_start, a_layer_index);
        end
        checks++; if (a_perf !== 32'd0) begin errors++; $display("FAIL mid_reset_perf got %0d exp 0", a_perf); end
        @(posedge clock); #1 reset = 0;
        run_inf(1, 2, 3, 1);
    endtask

    // Watchdog-disabled instance must ride out a 10000-cycle stall.
    task automatic test_no_timeout();
        int berr;
        do_reset(3'b000);
        berr = 0;
        for (int k = 0; k <= 10002; k++) begin
            @(posedge clock); #1;
            start = (k == 0);
            if (k >= 1) layer_done[0] = 1'b0;
            @(negedge clock);
            if (k >= 1 && (b_error !== 1'b0 || b_busy !== 1'b1)) berr++;
        end
        checks++; if (berr != 0) begin errors++; $display("FAIL no_timeout_stall got %0d bad cycles exp 0", berr); end
        checks++; if (a_error !== 1'b1) begin errors++; $display("FAIL a_stall_error got %b exp 1", a_error); end
        @(posedge clock); #1; layer_done[0] = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (b_layer_start !== 3'b010) begin errors++; $display("FAIL no_timeout_advance got %b exp 010", b_layer_start); end
        checks++; if (b_error !== 1'b0) begin errors++; $display("FAIL no_timeout_error got %b exp 0", b_error); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_expire_boundary();
        test_random();
        test_timeout();
        test_held_done();
        test_reset_mid();
        test_no_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
